// File: rtl/xnor_skolem_seq_if.sv
// rtl/xnor_skolem_seq_if.sv - input/output handshake bundle for the sequential xnor Skolem evaluator
interface xnor_skolem_seq_if #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] out_vec;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec
    );
endinterface

// File: rtl/xnor_skolem_seq.sv
// rtl/xnor_skolem_seq.sv - sequential Skolem evaluator for xnor_N_M, CHUNK parity bits folded per cycle
// Optional output self-check enabled by macro SKOLEM_SELFCHECK_EN.
module xnor_skolem_seq #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 2,
    parameter int CHUNK = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    xnor_skolem_seq_if.slave   bus,
    output logic               busy,
    output logic [CNT_W-1:0]   eval_count,
    output logic               spec_err
);
    localparam int NCH   = (N_IN + CHUNK - 1) / CHUNK;
    localparam int PW    = NCH * CHUNK;
    localparam int IDX_W = $clog2(NCH + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t           state, state_next;
    logic [N_IN-1:0]  shadow;
    logic [PW-1:0]    work;
    logic [IDX_W-1:0] idx;
    logic             acc, acc_next;
    logic [N_OUT-1:0] y_lo, y, out_vec_r;
    logic             in_ready_c, out_valid_c;
    logic             accept, emit_hs, last_chunk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = ACCUM;
            end
            ACCUM: begin
                if (last_chunk) state_next = EMIT;
            end
            EMIT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept     = in_ready_c & bus.in_valid;
    assign emit_hs    = out_valid_c & bus.out_ready;
    // The idx==NCH pass folds only padding, giving the registered output its own cycle.
    assign last_chunk = (idx == IDX_W'(NCH));
    assign acc_next   = acc ^ (^work[CHUNK-1:0]);

    for (genvar k = 0; k < N_OUT - 1; k++) begin : g_copy
        assign y_lo[k] = shadow[k % N_IN];
    end
    assign y_lo[N_OUT-1] = 1'b0;
    // Top bit cancels the parity of the inputs and of the copied low bits.
    assign y = y_lo ^ (N_OUT'(acc_next ^ (^y_lo)) << (N_OUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            work       <= '0;
            idx        <= '0;
            acc        <= 1'b0;
            out_vec_r  <= '0;
            eval_count <= '0;
        end else begin
            if (accept) begin
                shadow <= bus.in_vec;
                work   <= PW'(bus.in_vec);
                idx    <= '0;
                acc    <= 1'b0;
            end else if (state == ACCUM) begin
                work <= work >> CHUNK;
                idx  <= idx + 1'b1;
                acc  <= acc_next;
                if (last_chunk) out_vec_r <= y;
            end
            if (emit_hs && !(&eval_count)) eval_count <= eval_count + 1'b1;
        end
    end

`ifdef SKOLEM_SELFCHECK_EN
    logic chk_bad;
    assign chk_bad = (^shadow) ^ (^out_vec_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  spec_err <= 1'b0;
        else if (emit_hs && chk_bad) spec_err <= 1'b1;
    end
`else
    assign spec_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_vec   = out_vec_r;
    assign busy          = ~in_ready_c;
endmodule
